// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp_13 add/sub scheduler.
// Arbitration policy is selected in fp_sched_arb by FP_SCHED_RR_EN.
package fp_sched_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned FP_SCHED_ID_W = 3;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_SUB = 1'b1;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  typedef struct packed {
    logic                     vld;
    logic [FP_SCHED_ID_W-1:0] id;
  } fp_tag_t;

endpackage

// File: rtl/fp_sched_arb.sv
// Combinational one-hot grant. FP_SCHED_RR_EN selects round-robin from ptr_i+1;
// otherwise fixed priority, lowest eligible index wins, and ptr_i is absent.
module fp_sched_arb
  import fp_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          elig_i,
`ifdef FP_SCHED_RR_EN
  input  logic [FP_SCHED_ID_W-1:0] ptr_i,
`endif
  output logic [NREQ-1:0]          gnt_o
);

  logic        found;
  int unsigned idx;

`ifdef FP_SCHED_RR_EN
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(ptr_i) + off) % NREQ;
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = i;
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fp_add_sched.sv
// Shares one external fp_13 add/sub unit among NREQ requesters, tracking
// in-flight ops with a tag pipeline. FP_SCHED_RR_EN enables round-robin arbitration.
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NREQ-1:0][31:0] rsp_c,
  output logic                  add_vld,
  output logic                  add_op,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_c,
  output logic                  idle
);

  logic [NREQ-1:0]          busy_q, busy_d;
  logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
  fp32_t [NREQ-1:0]         rsp_c_q, rsp_c_d;
  logic                     op_q, op_d;
  fp32_t                    op_a_q, op_a_d, op_b_q, op_b_d;
  fp_tag_t                  tag_q [ADD_LAT];
  fp_tag_t                  tag_d [ADD_LAT];
  logic [NREQ-1:0]          elig, gnt_raw, gnt;
  logic                     gnt_any;
  logic [FP_SCHED_ID_W-1:0] gnt_id;
  logic                     tag_busy;

  assign elig = req_valid & ~busy_q;

`ifdef FP_SCHED_RR_EN
  logic [FP_SCHED_ID_W-1:0] ptr_q, ptr_d;

  fp_sched_arb #(.NREQ(NREQ)) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt_raw)
  );

  always_comb ptr_d = gnt_any ? gnt_id : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= FP_SCHED_ID_W'(NREQ - 1);
    else      ptr_q <= ptr_d;
  end
`else
  fp_sched_arb #(.NREQ(NREQ)) u_arb (
    .elig_i (elig),
    .gnt_o  (gnt_raw)
  );
`endif

  // No grant may leak out while reset is held low.
  assign gnt     = rst ? gnt_raw : '0;
  assign gnt_any = |gnt;

  always_comb begin
    gnt_id = '0;
    op_d   = op_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id = FP_SCHED_ID_W'(i);
        op_d   = req_op[i];
        op_a_d = req_a[i];
        op_b_d = req_b[i];
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    tag_d[0]    = '{vld: gnt_any, id: gnt_id};
    for (int unsigned k = 1; k < ADD_LAT; k++) tag_d[k] = tag_q[k-1];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) busy_d[i] = 1'b1;
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        busy_d[i]      = 1'b0;
        rsp_valid_d[i] = 1'b0;
      end
      // One outstanding op per requester, so capture never meets a handshake.
      if (tag_q[ADD_LAT-1].vld && tag_q[ADD_LAT-1].id == FP_SCHED_ID_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
        rsp_c_d[i]     = add_c;
      end
    end
  end

  always_comb begin
    tag_busy = 1'b0;
    for (int unsigned k = 0; k < ADD_LAT; k++) tag_busy = tag_busy | tag_q[k].vld;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
      op_q        <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      for (int unsigned k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      op_q        <= op_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      for (int unsigned k = 0; k < ADD_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign req_ready = gnt;
  assign add_vld   = gnt_any;
  assign add_op    = op_d;
  assign add_a     = op_a_d;
  assign add_b     = op_b_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign idle      = ~|busy_q & ~tag_busy;

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Scheduler that shares one `fp_13` single-precision add/sub unit among `NREQ` requesters. Each requester issues one operation at a time over a valid/ready handshake. The block arbitrates, drives the adder operands, tracks in-flight operations through the adder's fixed latency, and returns each result to its owner. The result is held until the owner accepts it. The block sits between the requester ports and the adder instance.

## Interface
- `NREQ`, 4: number of requesters, range 2..8.
- `ADD_LAT`, 2: adder latency in cycles, range 1..8. Operands driven in cycle t produce `add_c` valid in cycle t+`ADD_LAT`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in `NREQ`: request present, per requester.
- `req_ready` out `NREQ`: request accepted this cycle; at most one bit high.
- `req_op` in `NREQ`: 0 = add, 1 = subtract (a−b).
- `req_a`, `req_b` in `NREQ`×32: IEEE-754 single-precision operands.
- `rsp_valid` out `NREQ`: result held for the requester.
- `rsp_ready` in `NREQ`: requester consumes its result.
- `rsp_c` out `NREQ`×32: per-requester result register.
- `add_vld` out 1: operands valid this cycle.
- `add_op` out 1: op to adder.
- `add_a`, `add_b` out 32: operands to adder.
- `add_c` in 32: adder result.
- `idle` out 1: no busy requester and no operation in flight.

## Operation
- Per-requester `busy[i]` bit.
- Eligibility: `req_valid[i] && !busy[i]`.
- Each cycle at most one eligible requester is granted.
- Grant i drives:
  - `req_ready[i]=1`.
  - `add_vld=1`.
  - `add_op`/`add_a`/`add_b` = requester i's inputs.
  - `busy[i]` set at the edge.
- No eligible requester: `add_vld=0`, operands held at their last value.
- `req_ready` is combinational from `req_valid`, `busy` and arbitration state. Requesters must not make `req_valid` depend on `req_ready`.
- Tag pipeline, depth `ADD_LAT`: entries of {vld, id[$clog2(NREQ)]}. It is shifted every cycle, and a grant pushes {1,i}.
- Tag exiting with vld=1 and id=i: `add_c` captured into `rsp_c[i]`, `rsp_valid[i]` set.
- `rsp_valid[i] && rsp_ready[i]` at an edge clears `rsp_valid[i]` and `busy[i]`. Requester i is eligible again the following cycle, never in the same cycle as its response handshake.
- Capture and handshake cannot collide for the same i, because `busy` permits one outstanding operation per requester.
- `rsp_c[i]` holds its value after the handshake until overwritten.
- `idle` = no `busy` bit set and no tag vld set.
- No arithmetic is performed in this block. Special values (NaN, inf, zero) pass through unchanged.

## Timing
- Reset (`rst` low), asynchronous:
  - `busy`, tag pipeline, `rsp_valid` = 0.
  - `rsp_c` = 0.
  - `add_op`, `add_a`, `add_b` = 0.
  - Arbitration pointer = `NREQ`−1.
- Outputs while `rst` is low: `req_ready`=0, `add_vld`=0, `idle`=1.
- Reset mid-operation: in-flight tags are discarded. `add_c` values arriving after reset release are ignored.
- Latency, request to `rsp_valid`:
  - Grant in cycle t; `rsp_valid` high from cycle t+`ADD_LAT`+1.
  - Minimum turnaround per requester is `ADD_LAT`+2 cycles.
- Throughput: one grant per cycle when different requesters are eligible.
- Simultaneous requests: resolved by the arbitration policy (see Configuration). A non-granted request stays pending with `req_valid` held.

## Configuration
- `FP_SCHED_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer+1, modulo `NREQ`.
  - The pointer updates to the granted index only on a grant.
- `FP_SCHED_RR_EN` undefined: fixed priority, lowest eligible index wins. The pointer register is not built.

## Structure
- Package `fp_sched_pkg`:
  - `fp32_t` packed struct {s, e[7:0], m[22:0]}.
  - `FP_OP_ADD`=0, `FP_OP_SUB`=1.
  - `fp_tag_t` struct {vld, id}.
- Sub-module `fp_sched_arb`: combinational one-hot grant from eligibility and pointer, with the policy selected by `FP_SCHED_RR_EN`.
- Busy bits, tag pipeline and response registers live in `fp_add_sched`.

## Test plan
All scenarios use `ADD_LAT`=2.
- **Single add.** Requester 0: `req_op`=0, a=0x41800000 (16.0), b=0x3f800000 (1.0), granted cycle t -> `add_vld` in t; `rsp_valid[0]` at t+3; `rsp_c[0]`=0x41880000.
- **Single sub.** Requester 1: `req_op`=1, same operands -> `rsp_c[1]`=0x41700000 (15.0). Then a=0xc1800000, b=0xbf800000 subtract -> 0xc1700000.
- **Contention.** All four requesters valid in the same cycle, responses always accepted:
  - RR build: grants in order 0,1,2,3 over four consecutive cycles; four results in order; `idle` returns to 1.
  - Fixed-priority build, requester 0 re-requesting immediately: requester 0 is granted each time it is eligible, and 3 waits while 1 and 2 drain first.
- **Backpressure.** Requester 2 holds `rsp_ready`=0 for 10 cycles with `req_valid` high -> `rsp_c[2]` stable, `req_ready[2]`=0 throughout. Grant no earlier than the cycle after `rsp_ready` rises.
- **Reset mid-flight.** Assert `rst` low one cycle after a grant -> after release, `rsp_valid`=0, `idle`=1, and the stale `add_c` is never captured.
- **Back-to-back interleave.** Requesters 0 and 1 alternate requests for 20 operations with random operands -> each `rsp_c` matches a reference model, and the result lands at the owner that issued it.
